// File: rtl/seq_match_if.sv
// Host/stream bundle for the serial pattern-match run controller.
// The master side drives config, run control and the bit stream; the slave side reports run status.
interface seq_match_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int WIN_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
);
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [WIN_W-1:0]   cfg_window;
    logic               start;
    logic               abort;
    logic               x_valid;
    logic               x;
    logic               busy;
    logic               done;
    logic               aborted;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_window,
        output start, abort, x_valid, x,
        input  busy, done, aborted, match, match_cnt
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_window,
        input  start, abort, x_valid, x,
        output busy, done, aborted, match, match_cnt
    );
endinterface

// File: rtl/seq_match_ctrl.sv
// Run controller for a programmable serial pattern matcher: config shadow, IDLE/RUN/DONE sequencing,
// window-bounded bit acceptance and a saturating match counter.
module seq_match_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int WIN_W   = 16
) (
    input logic       clk,
    input logic       rst_n,
    seq_match_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;

    logic [MAX_LEN-1:0] sh_pattern;
    logic [LEN_W-1:0]   sh_len;
    logic               sh_overlap;
    logic [WIN_W-1:0]   sh_window;

    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic [WIN_W-1:0]   window;

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [WIN_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt;
    logic               match_r;
    logic               aborted_r;

    logic               take_cfg;
    logic [MAX_LEN-1:0] start_pattern;
    logic [LEN_W-1:0]   start_len;
    logic               start_overlap;
    logic [WIN_W-1:0]   start_window;

    logic               accept;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;
    logic [WIN_W-1:0]   bit_cnt_next;
    logic               last_bit;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] raw);
        if (raw == '0)
            return LEN_W'(1);
        else if (raw > LEN_W'(MAX_LEN))
            return LEN_W'(MAX_LEN);
        else
            return raw;
    endfunction

    // A write landing in the start cycle takes effect for the run it starts.
    assign take_cfg      = bus.cfg_we && (state != RUN);
    assign start_pattern = take_cfg ? bus.cfg_pattern : sh_pattern;
    assign start_len     = clamp_len(take_cfg ? bus.cfg_len : sh_len);
    assign start_overlap = take_cfg ? bus.cfg_overlap : sh_overlap;
    assign start_window  = take_cfg ? bus.cfg_window  : sh_window;

    always_comb begin
        accept       = (state == RUN) && !bus.abort && (window != '0) && bus.x_valid;
        hist_next    = {hist[MAX_LEN-2:0], bus.x};
        fill_next    = (fill >= len) ? len : fill + LEN_W'(1);
        len_mask     = ~({MAX_LEN{1'b1}} << len);
        hit          = accept && (fill_next >= len) &&
                       ((hist_next & len_mask) == (pattern & len_mask));
        bit_cnt_next = bit_cnt + WIN_W'(1);
        last_bit     = accept && (bit_cnt_next == window);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sh_pattern <= MAX_LEN'(11);
            sh_len     <= LEN_W'(4);
            sh_overlap <= 1'b0;
            sh_window  <= WIN_W'(16);
            pattern    <= MAX_LEN'(11);
            len        <= LEN_W'(4);
            overlap    <= 1'b0;
            window     <= WIN_W'(16);
            hist       <= '0;
            fill       <= '0;
            bit_cnt    <= '0;
            cnt        <= '0;
            match_r    <= 1'b0;
            aborted_r  <= 1'b0;
        end else begin
            match_r <= 1'b0;
            if (take_cfg) begin
                sh_pattern <= bus.cfg_pattern;
                sh_len     <= bus.cfg_len;
                sh_overlap <= bus.cfg_overlap;
                sh_window  <= bus.cfg_window;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        pattern   <= start_pattern;
                        len       <= start_len;
                        overlap   <= start_overlap;
                        window    <= start_window;
                        hist      <= '0;
                        fill      <= '0;
                        bit_cnt   <= '0;
                        cnt       <= '0;
                        aborted_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state     <= DONE;
                        aborted_r <= 1'b1;
                    end else if (window == '0) begin
                        state <= DONE;
                    end else if (accept) begin
                        hist    <= hist_next;
                        bit_cnt <= bit_cnt_next;
                        // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
                        fill    <= (hit && !overlap) ? '0 : fill_next;
                        if (hit) begin
                            match_r <= 1'b1;
                            if (cnt != '1)
                                cnt <= cnt + CNT_W'(1);
                        end
                        if (last_bit)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.match     = match_r;
    assign bus.aborted   = aborted_r;
    assign bus.match_cnt = cnt;
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl: table-driven runs through a match/done scoreboard,
// plus hand-written sequences for saturation, mid-run config writes, async reset and abort.
module tb_seq_match_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_match_if bus();

    seq_match_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  pattern;
        logic [3:0]  len;
        logic        overlap;
        logic [15:0] window;
        logic [31:0] stream;
        int          exp_cnt;
    } vec_t;

    typedef struct {
        logic match;
        logic done;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    logic       mdl_bits[$];
    logic [7:0] mdl_pat;
    int         mdl_len;
    logic       mdl_ov;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic xv, input logic xb, input logic ab, input logic st);
        bus.x_valid = xv;
        bus.x       = xb;
        bus.abort   = ab;
        bus.start   = st;
        step();
        bus.x_valid = 1'b0;
        bus.abort   = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic setCfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [15:0] w);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = p;
        bus.cfg_len     = l;
        bus.cfg_overlap = ov;
        bus.cfg_window  = w;
    endtask

    // Garbage on the config inputs proves a start without cfg_we reads the shadow.
    task automatic scrambleCfg();
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = 8'h5A;
        bus.cfg_len     = 4'd2;
        bus.cfg_overlap = 1'b1;
        bus.cfg_window  = 16'd3;
    endtask

    task automatic modelStart(input logic [7:0] p, input logic [3:0] l, input logic ov);
        mdl_bits.delete();
        mdl_pat = p;
        mdl_ov  = ov;
        mdl_len = (l == 4'd0) ? 1 : ((l > 4'd8) ? 8 : int'(l));
    endtask

    task automatic modelAccept(input logic b, output logic m);
        int n;
        mdl_bits.push_back(b);
        if (mdl_bits.size() > 8)
            void'(mdl_bits.pop_front());
        n = mdl_bits.size();
        m = 1'b0;
        if (n >= mdl_len) begin
            m = 1'b1;
            for (int k = 0; k < mdl_len; k++)
                if (mdl_bits[n - mdl_len + k] !== mdl_pat[mdl_len - 1 - k])
                    m = 1'b0;
        end
        if (m && !mdl_ov)
            mdl_bits.delete();
    endtask

    task automatic sbCheck(input string name);
        exp_t e;
        if (sbq.size() == 0) begin
            fails++;
            $display("[TB] FAIL %s: scoreboard empty, got match=%0d done=%0d", name, bus.match, bus.done);
        end else begin
            e = sbq.pop_front();
            checkOutput({name, " match"}, 32'(bus.match), 32'(e.match));
            checkOutput({name, " done"}, 32'(bus.done), 32'(e.done));
        end
    endtask

    task automatic feedBit(input logic b, input logic last, input string name);
        logic m;
        exp_t e;
        modelAccept(b, m);
        e.match = m;
        e.done  = last;
        sbq.push_back(e);
        applyStimulus(1'b1, b, 1'b0, 1'b0);
        sbCheck(name);
    endtask

    task automatic feedStall(input string name);
        exp_t e;
        e.match = 1'b0;
        e.done  = 1'b0;
        sbq.push_back(e);
        applyStimulus(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
        sbCheck(name);
    endtask

    task automatic runVector(input vec_t v, input int idx);
        string nm;
        exp_t  e;
        int    w;
        nm = $sformatf("vec%0d", idx);
        w  = int'(v.window);
        modelStart(v.pattern, v.len, v.overlap);
        setCfg(v.pattern, v.len, v.overlap, v.window);
        if (idx % 2 == 1) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            scrambleCfg();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            bus.cfg_we = 1'b0;
        end
        checkOutput({nm, " busy after start"}, 32'(bus.busy), 1);
        checkOutput({nm, " cnt after start"}, 32'(bus.match_cnt), 0);
        if (w == 0) begin
            e.match = 1'b0;
            e.done  = 1'b1;
            sbq.push_back(e);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            sbCheck({nm, " empty window"});
        end else begin
            for (int i = 0; i < w; i++) begin
                feedBit(v.stream[w - 1 - i], (i == w - 1), $sformatf("%s bit%0d", nm, i + 1));
                if (i % 3 == 2 && i != w - 1)
                    feedStall($sformatf("%s stall%0d", nm, i + 1));
            end
        end
        checkOutput({nm, " final cnt"}, 32'(bus.match_cnt), v.exp_cnt);
        checkOutput({nm, " aborted"}, 32'(bus.aborted), 0);
        checkOutput({nm, " busy in done"}, 32'(bus.busy), 0);
        step();
        checkOutput({nm, " done pulse width"}, 32'(bus.done), 0);
        checkOutput({nm, " cnt held"}, 32'(bus.match_cnt), v.exp_cnt);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'b0000_1011, 4'd4,  1'b0, 16'd10, 32'b1011011011, 2};
        vecs[1] = '{8'b0000_1011, 4'd4,  1'b1, 16'd10, 32'b1011011011, 3};
        vecs[2] = '{8'b0000_0001, 4'd0,  1'b0, 16'd6,  32'b101101,     4};
        vecs[3] = '{8'b1100_1010, 4'd12, 1'b0, 16'd10, 32'b1111001010, 1};
        vecs[4] = '{8'b0000_1011, 4'd4,  1'b0, 16'd0,  32'b0,          0};
        vecs[5] = '{8'b0000_0110, 4'd3,  1'b1, 16'd8,  32'b11011011,   2};
        vecs[6] = '{8'b0000_0101, 4'd4,  1'b0, 16'd10, 32'b0101010101, 2};
        vecs[7] = '{8'b0000_0101, 4'd4,  1'b1, 16'd10, 32'b0101010101, 4};

        rst_n = 1'b0;
        bus.x_valid = 1'b0;
        bus.x       = 1'b0;
        bus.abort   = 1'b0;
        bus.start   = 1'b0;
        scrambleCfg();
        step();
        step();
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset done", 32'(bus.done), 0);
        checkOutput("reset match", 32'(bus.match), 0);
        checkOutput("reset aborted", 32'(bus.aborted), 0);
        checkOutput("reset cnt", 32'(bus.match_cnt), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++)
            runVector(vecs[i], i);

        // Saturation: every bit matches, counter must stick at all-ones.
        setCfg(8'b0000_0001, 4'd1, 1'b0, 16'd300);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        bus.cfg_we = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 255) checkOutput("sat cnt at 255", 32'(bus.match_cnt), 255);
            if (i == 299) begin
                checkOutput("sat no early done", 32'(bus.done), 0);
                checkOutput("sat cnt held", 32'(bus.match_cnt), 255);
            end
            if (i == 300) begin
                checkOutput("sat done", 32'(bus.done), 1);
                checkOutput("sat last match", 32'(bus.match), 1);
                checkOutput("sat final cnt", 32'(bus.match_cnt), 255);
            end
        end
        step();

        // Config write during a run must not touch the shadow or the current run.
        setCfg(8'b0000_1011, 4'd4, 1'b0, 16'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        modelStart(8'b0000_1011, 4'd4, 1'b0);
        setCfg(8'b0000_0001, 4'd1, 1'b1, 16'd2);
        feedBit(1'b1, 1'b0, "cfgrun bit1");
        feedBit(1'b0, 1'b0, "cfgrun bit2");
        bus.cfg_we = 1'b0;
        feedBit(1'b1, 1'b0, "cfgrun bit3");
        feedBit(1'b1, 1'b1, "cfgrun bit4");
        checkOutput("cfgrun cnt", 32'(bus.match_cnt), 1);
        step();
        scrambleCfg();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        modelStart(8'b0000_1011, 4'd4, 1'b0);
        feedBit(1'b0, 1'b0, "shadow bit1");
        feedBit(1'b0, 1'b0, "shadow bit2");
        feedBit(1'b0, 1'b0, "shadow bit3");
        feedBit(1'b1, 1'b1, "shadow bit4");
        checkOutput("shadow cnt", 32'(bus.match_cnt), 0);
        step();

        // Asynchronous reset in the middle of a run.
        setCfg(8'b0000_0001, 4'd1, 1'b1, 16'd20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        bus.cfg_we = 1'b0;
        modelStart(8'b0000_0001, 4'd1, 1'b1);
        feedBit(1'b1, 1'b0, "prereset bit1");
        feedBit(1'b1, 1'b0, "prereset bit2");
        feedBit(1'b1, 1'b0, "prereset bit3");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst busy", 32'(bus.busy), 0);
        checkOutput("async rst match", 32'(bus.match), 0);
        checkOutput("async rst cnt", 32'(bus.match_cnt), 0);
        checkOutput("async rst done", 32'(bus.done), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("post reset no done", 32'(bus.done), 0);
        end

        // Default shadow, stalls, then abort on the bit that would complete a match.
        scrambleCfg();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        modelStart(8'b0000_1011, 4'd4, 1'b0);
        feedBit(1'b1, 1'b0, "abort bit1");
        feedStall("abort stall1");
        feedBit(1'b0, 1'b0, "abort bit2");
        feedStall("abort stall2");
        feedBit(1'b1, 1'b0, "abort bit3");
        feedBit(1'b1, 1'b0, "abort bit4");
        feedStall("abort stall3");
        feedBit(1'b1, 1'b0, "abort bit5");
        feedBit(1'b0, 1'b0, "abort bit6");
        feedBit(1'b1, 1'b0, "abort bit7");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("abort no match", 32'(bus.match), 0);
        checkOutput("abort done", 32'(bus.done), 1);
        checkOutput("abort aborted", 32'(bus.aborted), 1);
        checkOutput("abort cnt", 32'(bus.match_cnt), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("start in done ignored", 32'(bus.busy), 0);
        checkOutput("aborted sticky", 32'(bus.aborted), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("abort in idle ignored", 32'(bus.done), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("restart clears aborted", 32'(bus.aborted), 0);
        checkOutput("restart busy", 32'(bus.busy), 1);
        checkOutput("restart cnt", 32'(bus.match_cnt), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("stall abort done", 32'(bus.done), 1);
        checkOutput("stall abort aborted", 32'(bus.aborted), 1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
